// File: rtl/dbus_responder.sv
// Single-port data-bus responder: one 64-bit word memory behind a dreq/dresp handshake.
// Optional misaligned-access fault reporting via `define DBUS_RESP_MISALIGN_CHECK_EN.
package dbus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [7:0]      strb_q;
    logic [63:0]     wdata_q;
    logic            mis_q;
    logic            data_ok_q;
    logic            err_q;
    logic            mis_d;
    logic            unused_bits;

    logic [63:0]     mem [DEPTH];

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    always_comb begin
        mis_d = 1'b0;
        unique case (dreq.size)
            MSIZE2:  mis_d = dreq.addr[0];
            MSIZE4:  mis_d = |dreq.addr[1:0];
            MSIZE8:  mis_d = |dreq.addr[2:0];
            default: mis_d = 1'b0;
        endcase
    end

    assign err = err_q;
    assign unused_bits = ^{dreq.addr[63:3+AW]};
`else
    assign mis_d = 1'b0;
    assign err   = 1'b0;
    assign unused_bits = ^{dreq.addr[63:3+AW], dreq.addr[2:0],
                           dreq.size, err_q};
`endif

    // Faulted accesses skip WAIT and report in the very next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            strb_q    <= 8'd0;
            wdata_q   <= 64'd0;
            mis_q     <= 1'b0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dreq.valid) begin
                        idx_q   <= dreq.addr[3 +: AW];
                        strb_q  <= dreq.strobe;
                        wdata_q <= dreq.data;
                        mis_q   <= mis_d;
                        cnt_q   <= CNT_INIT;
                        if (mis_d || LATENCY == 1) begin
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                            err_q     <= mis_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        err_q     <= mis_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain; an aborted access
    // never reaches RESP, so it can never commit.
    always_ff @(posedge clk) begin
        if (data_ok_q && strb_q != 8'd0 && !mis_q) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = (state_q == IDLE) && dreq.valid;
    assign dresp.data_ok = data_ok_q;
    assign dresp.data    = (data_ok_q && strb_q == 8'd0 && !mis_q)
                         ? mem[idx_q] : 64'd0;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: timing, byte merge, aliasing, reset abort,
// misalignment and LATENCY=1 back-to-back behaviour.
module tb_dbus_responder;
    import dbus_pkg::*;

    logic       clk;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       err;
    dbus_req_t  dreq1;
    dbus_resp_t dresp1;
    logic       err1;

    int checks;
    int errors;

    dbus_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp),
        .err   (err)
    );

    dbus_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq1),
        .dresp (dresp1),
        .err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, scrambles dreq after acceptance, waits for data_ok.
    task automatic access(input logic [63:0] a, input msize_t sz,
                          input logic [7:0] st, input logic [63:0] d,
                          output logic acc, output int lat,
                          output logic [63:0] rd, output logic e);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = sz;
        dreq.strobe = st;
        dreq.data   = d;
        #1 acc = dresp.addr_ok;
        @(negedge clk);
        lat = 1;
        dreq.valid  = 1'b0;
        dreq.addr   = ~a;
        dreq.strobe = ~st;
        dreq.data   = ~d;
        while (!dresp.data_ok && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = dresp.data;
        e  = err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dreq  = '0;
        dreq1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dresp !== 66'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h err %b want 0", dresp, err);
        end
        checks++;
        if (dresp1 !== 66'd0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs1 got %h err %b want 0", dresp1, err1);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_merge();
        logic acc, e;
        int lat;
        logic [63:0] rd;
        access(64'h8, MSIZE8, 8'hFF, 64'h1122334455667788, acc, lat, rd, e);
        checks++;
        if (acc !== 1'b1 || lat != 2 || rd !== 64'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_full acc %b lat %0d data %h err %b want 1 2 0 0",
                     acc, lat, rd, e);
        end
        access(64'h8, MSIZE8, 8'h0F, 64'hAAAAAAAAAAAAAAAA, acc, lat, rd, e);
        checks++;
        if (lat != 2 || rd !== 64'd0) begin
            errors++;
            $display("FAIL wr_part lat %0d data %h want 2 0", lat, rd);
        end
        access(64'h8, MSIZE8, 8'h00, 64'h0, acc, lat, rd, e);
        checks++;
        if (lat != 2 || rd !== 64'h11223344AAAAAAAA) begin
            errors++;
            $display("FAIL rd_merge lat %0d data %h want 2 11223344aaaaaaaa",
                     lat, rd);
        end
    endtask

    task automatic test_read_timing();
        logic acc, e;
        int lat;
        logic [63:0] rd;
        access(64'h10, MSIZE8, 8'hFF, 64'h0BADF00D0BADF00D, acc, lat, rd, e);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h10;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        #1;
        checks++;
        if (dresp.addr_ok !== 1'b1 || dresp.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL t0 addr_ok %b data_ok %b want 1 0",
                     dresp.addr_ok, dresp.data_ok);
        end
        @(negedge clk);
        checks++;
        if (dresp.addr_ok !== 1'b0 || dresp.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL t1 addr_ok %b data_ok %b want 0 0",
                     dresp.addr_ok, dresp.data_ok);
        end
        @(negedge clk);
        checks++;
        if (dresp.addr_ok !== 1'b0 || dresp.data_ok !== 1'b1 ||
            dresp.data !== 64'h0BADF00D0BADF00D) begin
            errors++;
            $display("FAIL t2 addr_ok %b data_ok %b data %h want 0 1 0badf00d0badf00d",
                     dresp.addr_ok, dresp.data_ok, dresp.data);
        end
        @(negedge clk);
        checks++;
        if (dresp.addr_ok !== 1'b1 || dresp.data_ok !== 1'b0 ||
            dresp.data !== 64'd0) begin
            errors++;
            $display("FAIL t3 addr_ok %b data_ok %b data %h want 1 0 0",
                     dresp.addr_ok, dresp.data_ok, dresp.data);
        end
        @(negedge clk);
        dreq.valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dresp.data_ok !== 1'b1) begin
            errors++;
            $display("FAIL t5_second_data_ok got %b want 1", dresp.data_ok);
        end
    endtask

    task automatic test_alias();
        logic acc, e;
        int lat;
        logic [63:0] rd;
        access(64'h0, MSIZE8, 8'hFF, 64'h5A, acc, lat, rd, e);
        access(64'h2000, MSIZE8, 8'h00, 64'h0, acc, lat, rd, e);
        checks++;
        if (rd !== 64'h5A) begin
            errors++;
            $display("FAIL alias got %h want 5a", rd);
        end
    endtask

    task automatic test_reset_abort();
        logic acc, e;
        int lat;
        int seen;
        logic [63:0] rd;
        access(64'h18, MSIZE8, 8'hFF, 64'hCAFE, acc, lat, rd, e);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h18;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD;
        @(negedge clk);
        dreq.valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (dresp !== 66'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset got %h err %b want 0", dresp, err);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dresp.data_ok) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_data_ok got %0d pulses want 0", seen);
        end
        access(64'h18, MSIZE8, 8'h00, 64'h0, acc, lat, rd, e);
        checks++;
        if (rd !== 64'hCAFE || lat != 2) begin
            errors++;
            $display("FAIL abort_mem got %h lat %0d want cafe 2", rd, lat);
        end
    endtask

    task automatic test_misalign();
        logic acc, e;
        int lat;
        logic [63:0] rd;
        access(64'h2, MSIZE4, 8'hFF, 64'h0123456789ABCDEF, acc, lat, rd, e);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        checks++;
        if (lat != 1 || e !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL mis_resp lat %0d err %b data %h want 1 1 0",
                     lat, e, rd);
        end
        access(64'h0, MSIZE8, 8'h00, 64'h0, acc, lat, rd, e);
        checks++;
        if (rd !== 64'h5A || e !== 1'b0) begin
            errors++;
            $display("FAIL mis_mem got %h err %b want 5a 0", rd, e);
        end
`else
        checks++;
        if (lat != 2 || e !== 1'b0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL mis_resp lat %0d err %b data %h want 2 0 0",
                     lat, e, rd);
        end
        access(64'h0, MSIZE8, 8'h00, 64'h0, acc, lat, rd, e);
        checks++;
        if (rd !== 64'h0123456789ABCDEF || e !== 1'b0) begin
            errors++;
            $display("FAIL mis_mem got %h err %b want 0123456789abcdef 0",
                     rd, e);
        end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dreq1.valid  = 1'b1;
        dreq1.addr   = 64'h0;
        dreq1.size   = MSIZE8;
        dreq1.strobe = 8'h00;
        dreq1.data   = 64'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (dresp1.addr_ok !== 1'(k % 2 == 0) ||
                dresp1.data_ok !== 1'(k % 2 == 1)) begin
                errors++;
                $display("FAIL b2b cycle %0d addr_ok %b data_ok %b want %b %b",
                         k, dresp1.addr_ok, dresp1.data_ok,
                         1'(k % 2 == 0), 1'(k % 2 == 1));
            end
            @(negedge clk);
        end
        dreq1.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_merge();
        test_read_timing();
        test_alias();
        test_reset_abort();
        test_misalign();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
